uart_rx_fsmd: RTL

- Receive-side counterpart of the UART transmitter: recovers frames from the serial line driven by the Tx block's serial output, Tx_s.
- Frame format: start bit (0), data_size data bits LSB first, optional parity bit, one stop bit (1). Line idles at 1.
- Single module containing a line synchroniser, sample/bit counters, a majority-vote sampler, a shift register and a control FSM.
- Presents each received word with a one-cycle valid strobe and error flags to the consuming logic.

---
 rtl/uart_rx_fsmd.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fsmd.sv
// UART receiver: two-flop line synchroniser, 3-sample majority vote per bit,
// LSB-first shift register, optional parity check and framing check.
module uart_rx_fsmd #(
   parameter int data_size           = 8,
   parameter int parity_on           = 1,
   parameter int even_parity         = 1,
   parameter int samples_per_bit     = 16,
   parameter int sampling_cntr_width = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Rx_s,
   output logic [data_size-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 rx_busy
);

   localparam int W = sampling_cntr_width;
   localparam logic [W-1:0] MID    = W'(samples_per_bit / 2);
   localparam logic [W-1:0] MID_M1 = W'(samples_per_bit / 2 - 1);
   localparam logic [W-1:0] MID_P1 = W'(samples_per_bit / 2 + 1);
   localparam logic [W-1:0] LAST_S = W'(samples_per_bit - 1);
   localparam logic [2:0]   LAST_BIT = 3'(data_size - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

   state_t               state;
   logic                 sync1, rx_sync;
   logic [W-1:0]         cnt;
   logic [2:0]           bit_cnt;
   logic                 v0, v1, par_bit;
   logic [data_size-1:0] sh;
   logic                 bit_v, decide, wrap, exp_par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         sync1   <= Rx_s;
         rx_sync <= sync1;
      end
   end

   // 2-of-3 vote: two registered captures around mid plus the live sample
   assign bit_v   = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
   assign decide  = (cnt == MID_P1);
   assign wrap    = (cnt == LAST_S);
   assign exp_par = (even_parity != 0) ? ^sh : ~(^sh);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         v0          <= 1'b0;
         v1          <= 1'b0;
         par_bit     <= 1'b0;
         sh          <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         rx_busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state != IDLE) begin
            cnt <= wrap ? '0 : cnt + W'(1);
            if (cnt == MID_M1) v0 <= rx_sync;
            if (cnt == MID)    v1 <= rx_sync;
         end
         case (state)
            IDLE: begin
               if (!rx_sync) begin
                  state   <= START;
                  rx_busy <= 1'b1;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end
            START: begin
               if (decide && bit_v) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end else if (wrap) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (decide) sh <= data_size'({bit_v, sh} >> 1);
               if (wrap) begin
                  if (bit_cnt == LAST_BIT) state <= (parity_on != 0) ? PARITY : STOP;
                  else                     bit_cnt <= bit_cnt + 3'd1;
               end
            end
            PARITY: begin
               if (decide) par_bit <= bit_v;
               if (wrap)   state <= STOP;
            end
            STOP: begin
               // leave at the decision point so a following start bit is not missed
               if (decide) begin
                  rx_data     <= sh;
                  rx_valid    <= 1'b1;
                  parity_err  <= (parity_on != 0) && (par_bit != exp_par);
                  framing_err <= !bit_v;
                  if (bit_v) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state <= BREAK_WAIT;
                  end
               end
            end
            BREAK_WAIT: begin
               if (rx_sync) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
